// File: rtl/c1908_resp_misr.sv
// Response compactor for the c1908 flow: folds each 25-bit core output word into a
// MISR and reports the final signature plus a pass/fail against a golden value.
module c1908_resp_misr #(
  parameter int               WIDTH     = 25,
  parameter int               VEC_COUNT = 8,
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(9)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] resp,
  input  logic             resp_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic             pass,
  output logic [16:0]      vec_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [16:0] LAST_IDX = 17'(VEC_COUNT - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] r_golden;
  logic [16:0]      r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [WIDTH-1:0] w_sig_next;
  logic             w_last;

  // Shift left, fold the outgoing MSB back through the taps, then mix in the response.
  assign w_sig_next = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ resp;
  assign w_last     = (r_cnt == LAST_IDX);

  // NOTE: every register here uses non-blocking assignments so all state updates
  // observe the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sig    <= '0;
      r_golden <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (abort) begin
      // Abort keeps the partial signature and count visible for debug.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_CAPTURE;
            r_sig    <= SEED;
            r_cnt    <= '0;
            r_golden <= golden;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (resp_valid) begin
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + 17'd1;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_sig_next == r_golden);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign pass      = r_pass;
  assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_c1908_resp_misr.sv
// Directed bench for c1908_resp_misr: three instances cover the default, two-vector
// and one-vector/MSB-seed configurations; expected values are hand-derived.
module tb_c1908_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [24:0] golden;
  logic [24:0] resp;
  logic        resp_valid;

  logic        busy0, done0, pass0;
  logic [24:0] sig0;
  logic [16:0] cnt0;
  logic        busy2, done2, pass2;
  logic [24:0] sig2;
  logic [16:0] cnt2;
  logic        busy1, done1, pass1;
  logic [24:0] sig1;
  logic [16:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;

  c1908_resp_misr u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
    .resp(resp), .resp_valid(resp_valid), .busy(busy0), .done(done0),
    .signature(sig0), .pass(pass0), .vec_cnt(cnt0)
  );

  c1908_resp_misr #(.VEC_COUNT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
    .resp(resp), .resp_valid(resp_valid), .busy(busy2), .done(done2),
    .signature(sig2), .pass(pass2), .vec_cnt(cnt2)
  );

  c1908_resp_misr #(.VEC_COUNT(1), .SEED(25'h1000000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .golden(golden),
    .resp(resp), .resp_valid(resp_valid), .busy(busy1), .done(done1),
    .signature(sig1), .pass(pass1), .vec_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic st, input logic ab, input logic rv, input logic [24:0] r);
    start      = st;
    abort      = ab;
    resp_valid = rv;
    resp       = r;
    @(posedge clk);
    #1;
    start      = 1'b0;
    abort      = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic check_dut0(input string tag, input logic b, input logic d, input logic p,
                            input logic [24:0] s, input logic [16:0] c);
    check({tag, ".busy"}, 32'(busy0), 32'(b));
    check({tag, ".done"}, 32'(done0), 32'(d));
    check({tag, ".pass"}, 32'(pass0), 32'(p));
    check({tag, ".sig"},  32'(sig0),  32'(s));
    check({tag, ".cnt"},  32'(cnt0),  32'(c));
  endtask

  logic [24:0] w4 [8];

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    golden = '0; resp = '0;
    w4 = '{25'h1000000, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0, 25'h0000003};

    // Reset state
    #12;
    check_dut0("reset", 1'b0, 1'b0, 1'b0, 25'h0, 17'd0);
    check("reset.sig1", 32'(sig1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: all-zero responses, default configuration
    golden = 25'h0;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    check_dut0("t1.start", 1'b1, 1'b0, 1'b0, 25'h0, 17'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 25'h0);
    check_dut0("t1.end", 1'b0, 1'b1, 1'b1, 25'h0, 17'd8);

    // Test 2: two-vector instance, 1 then 0 shifts to 2
    golden = 25'h0000002;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    check("t2.restart.done0", 32'(done0), 32'h0);
    check("t2.restart.pass0", 32'(pass0), 32'h0);
    check("t2.restart.busy0", 32'(busy0), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check("t2.mid.sig2", 32'(sig2), 32'h1);
    check("t2.mid.done2", 32'(done2), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 25'h0000000);
    check("t2.sig2", 32'(sig2), 32'h2);
    check("t2.done2", 32'(done2), 32'h1);
    check("t2.pass2", 32'(pass2), 32'h1);
    check("t2.cnt2", 32'(cnt2), 32'h2);

    // Test 3: MSB seed feeds back through the taps
    golden = 25'h0000009;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    check("t3.seed1", 32'(sig1), 32'h1000000);
    drive(1'b0, 1'b0, 1'b1, 25'h0);
    check("t3.sig1", 32'(sig1), 32'h9);
    check("t3.done1", 32'(done1), 32'h1);
    check("t3.pass1", 32'(pass1), 32'h1);
    check("t3.cnt1", 32'(cnt1), 32'h1);
    golden = 25'h0000008;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    drive(1'b0, 1'b0, 1'b1, 25'h0);
    check("t3b.sig1", 32'(sig1), 32'h9);
    check("t3b.done1", 32'(done1), 32'h1);
    check("t3b.pass1", 32'(pass1), 32'h0);

    // Test 4: gaps between valid words; gap-free reference is 25'h0000243
    drive(1'b0, 1'b1, 1'b0, 25'h0);
    golden = 25'h0000243;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, w4[i]);
      check($sformatf("t4.cnt%0d", i), 32'(cnt0), i + 1);
      if (i < 7) begin
        check($sformatf("t4.done%0d", i), 32'(done0), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 25'h1555555);
        check($sformatf("t4.gapcnt%0d", i), 32'(cnt0), i + 1);
      end
    end
    check_dut0("t4.end", 1'b0, 1'b1, 1'b1, 25'h0000243, 17'd8);
    drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check_dut0("t4.hold", 1'b0, 1'b1, 1'b1, 25'h0000243, 17'd8);

    // Test 5: ignored start in CAPTURE, abort, then a clean rerun
    golden = 25'h0000080;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check_dut0("t5.three", 1'b1, 1'b0, 1'b0, 25'h0000007, 17'd3);
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    check_dut0("t5.start_ign", 1'b1, 1'b0, 1'b0, 25'h0000007, 17'd3);
    drive(1'b0, 1'b1, 1'b0, 25'h0);
    check_dut0("t5.abort", 1'b0, 1'b0, 1'b0, 25'h0000007, 17'd3);
    drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check_dut0("t5.idle_ign", 1'b0, 1'b0, 1'b0, 25'h0000007, 17'd3);
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    check_dut0("t5.reload", 1'b1, 1'b0, 1'b0, 25'h0, 17'd0);
    drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 25'h0);
    check_dut0("t5.end", 1'b0, 1'b1, 1'b1, 25'h0000080, 17'd8);
    drive(1'b1, 1'b1, 1'b0, 25'h0);
    check_dut0("t5.abort_prio", 1'b0, 1'b0, 1'b0, 25'h0000080, 17'd8);

    // Test 6: asynchronous reset between edges mid-CAPTURE
    golden = 25'h0;
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check_dut0("t6.pre", 1'b1, 1'b0, 1'b0, 25'h0000007, 17'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_dut0("t6.async", 1'b0, 1'b0, 1'b0, 25'h0, 17'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 25'h0000001);
    check_dut0("t6.idle", 1'b0, 1'b0, 1'b0, 25'h0, 17'd0);
    drive(1'b1, 1'b0, 1'b0, 25'h0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 25'h0);
    check_dut0("t6.end", 1'b0, 1'b1, 1'b1, 25'h0, 17'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/c1908_resp_misr.md
Name: c1908_resp_misr

Overview:
- Downstream response compactor for the c1908 stimulus flow. Consumes the 25 primary outputs of the c1908 core (N2753..N2899, concatenated in port order with N2753 as MSB) once per applied vector.
- Folds each output word into a multiple-input signature register (MISR). After a programmed number of vectors it reports the final signature and a pass/fail result against a golden signature.
- Replaces per-vector file dumps with a single compact result for long aging runs.

Parameters:
- WIDTH, 25, response and signature width in bits.
- VEC_COUNT, 8, number of valid responses compacted per run; legal range 1..2^16.
- SEED, 25'h0000000, signature value loaded at run start.
- POLY, 25'h0000009, feedback taps for x^25+x^3+1; bit i set means the MSB is fed back into bit i.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a run.
- abort  input  1  terminates the current run and returns to IDLE.
- golden  input  WIDTH  expected signature, latched on an accepted start.
- resp  input  WIDTH  c1908 output word, MSB = N2753, LSB = N2899.
- resp_valid  input  1  resp holds a settled response this cycle.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.
- signature  output  WIDTH  current MISR contents.
- pass  output  1  signature == latched golden; valid only while done=1.
- vec_cnt  output  17  number of responses compacted in this run.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - signature=0, vec_cnt=0, busy=0, done=0, pass=0, golden latch=0.
- MISR update: sig_next = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ resp.
- FSM states: IDLE, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - start=1 -> signature<=SEED, vec_cnt<=0, golden latched, go to CAPTURE.
  - resp_valid is ignored.
- CAPTURE:
  - Each cycle with resp_valid=1: signature<=sig_next, vec_cnt<=vec_cnt+1.
  - When the accepted response is number VEC_COUNT (vec_cnt==VEC_COUNT-1 before the update): go to DONE and register pass=(sig_next==golden latch).
  - Cycles with resp_valid=0: signature and vec_cnt hold.
  - start is ignored.
- DONE:
  - done=1; signature, vec_cnt and pass hold.
  - resp_valid is ignored.
  - start=1 -> restart exactly as from IDLE, with done and pass cleared on that edge.
- abort=1 in any state -> IDLE next edge; signature and vec_cnt hold their last values, pass=0.
- Priority: abort over start over resp_valid.
- Latency:
  - busy rises one cycle after start.
  - done and pass rise on the edge that accepts the final response.
  - signature is final in that same cycle.
- vec_cnt never exceeds VEC_COUNT; there is no wrap within a run.
- Reset asserted mid-run clears everything immediately, independent of clk.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, then start with SEED=0 and golden=0, followed by 8 resp_valid cycles with resp=0 -> done=1 after the 8th edge, signature=25'h0000000, pass=1, vec_cnt=8.
- VEC_COUNT=2, SEED=0, resp=25'h0000001 then 25'h0000000 -> signature=25'h0000002 at done.
- SEED=25'h1000000, VEC_COUNT=1, resp=25'h0000000 -> MSB feedback gives signature=25'h0000009. With golden=25'h0000009 -> pass=1; with golden=25'h0000008 -> pass=0.
- Default config with resp_valid low on alternate cycles and 8 valid words applied -> vec_cnt steps only on valid cycles. Signature equals the gap-free reference, and done asserts only after the 8th valid word.
- Stimulus: start, 3 valid words, then start again (ignored); then abort. Then start, 8 words -> after the first start busy=1 and vec_cnt=3; abort -> IDLE with pass=0. The second start reloads SEED and the run completes normally with vec_cnt=8.
- Stimulus: drop rst_n between clock edges mid-CAPTURE -> all outputs zero immediately with state IDLE; a subsequent start behaves as after power-on.
